prefetch_queue: RTL



---
 rtl/prefetch_queue_pkg.sv | 23 ++
 rtl/prefetch_byte_ring.sv | 81 ++++++++
 rtl/prefetch_queue.sv | 112 +++++++++++
 3 files changed

// File: rtl/prefetch_queue_pkg.sv
// Shared widths, memory command encoding and FSM states for the prefetch queue.
package prefetch_queue_pkg;

  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned ADDRESS_WIDTH   = 32;
  localparam int unsigned QUEUE_BYTES     = 16;
  localparam int unsigned WINDOW_BYTES    = 15;
  localparam int unsigned MAX_INSTR_WIDTH = WINDOW_BYTES * 8;
  localparam int unsigned WORD_BYTES      = DATA_WIDTH / 8;
  localparam int unsigned PTR_WIDTH       = $clog2(QUEUE_BYTES);
  localparam int unsigned COUNT_WIDTH     = PTR_WIDTH + 1;
  localparam int unsigned LEN_WIDTH       = 4;

  // Only reads are ever issued; kept so the memory side shares one encoding.
  localparam logic MEM_CMD_READ = 1'b1;

  typedef enum logic [1:0] {
    PQ_IDLE = 2'd0,
    PQ_REQ  = 2'd1,
    PQ_WAIT = 2'd2
  } pq_state_e;

endpackage

// File: rtl/prefetch_byte_ring.sv
// Byte ring: 1-4 byte writes with a start offset, 0-15 byte read advance,
// and a registered little-endian window starting at the read pointer.
module prefetch_byte_ring
  import prefetch_queue_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic [1:0]                 wr_skip,
  input  logic [LEN_WIDTH-1:0]       rd_len,
  output logic [MAX_INSTR_WIDTH-1:0] window,
  output logic [COUNT_WIDTH-1:0]     count
);

  logic [7:0]                 ring_q [QUEUE_BYTES];
  logic [7:0]                 ring_d [QUEUE_BYTES];
  logic [PTR_WIDTH-1:0]       rd_ptr;
  logic [PTR_WIDTH-1:0]       wr_ptr;
  logic [PTR_WIDTH-1:0]       rd_ptr_d;
  logic [PTR_WIDTH-1:0]       wr_ptr_d;
  logic [COUNT_WIDTH-1:0]     count_d;
  logic [2:0]                 wr_bytes;
  logic [MAX_INSTR_WIDTH-1:0] window_d;

  // Next ring contents, pointers, occupancy and the window they imply.
  always_comb begin
    ring_d   = ring_q;
    wr_bytes = wr_en ? (3'd4 - 3'(wr_skip)) : 3'd0;
    rd_ptr_d = rd_ptr;
    wr_ptr_d = wr_ptr;
    count_d  = count;
    window_d = '0;

    if (wr_en) begin
      for (int i = 0; i < int'(WORD_BYTES); i++) begin
        if (i >= int'(wr_skip)) begin
          ring_d[PTR_WIDTH'(wr_ptr + PTR_WIDTH'(i) - PTR_WIDTH'(wr_skip))] = wr_data[8*i +: 8];
        end
      end
    end

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr + PTR_WIDTH'(wr_bytes);
      rd_ptr_d = rd_ptr + PTR_WIDTH'(rd_len);
      count_d  = count + COUNT_WIDTH'(wr_bytes) - COUNT_WIDTH'(rd_len);
    end

    for (int k = 0; k < int'(WINDOW_BYTES); k++) begin
      if (COUNT_WIDTH'(k) < count_d) begin
        window_d[8*k +: 8] = ring_d[PTR_WIDTH'(rd_ptr_d + PTR_WIDTH'(k))];
      end
    end
  end

  // Pointer, occupancy and window registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      window <= '0;
    end else begin
      rd_ptr <= rd_ptr_d;
      wr_ptr <= wr_ptr_d;
      count  <= count_d;
      window <= window_d;
    end
  end

  // Byte storage; stale bytes are masked by the occupancy count.
  always_ff @(posedge clk) begin
    ring_q <= ring_d;
  end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: sequential word reads into a byte ring,
// variable-length consume, and PC redirect with stale-response discard.
module prefetch_queue
  import prefetch_queue_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_pc_valid,
  input  logic [ADDRESS_WIDTH-1:0]   i_pc,
  output logic                       o_mem_valid,
  output logic [ADDRESS_WIDTH-1:0]   o_mem_addr,
  input  logic                       i_mem_ready,
  input  logic                       i_mem_valid,
  input  logic [DATA_WIDTH-1:0]      i_mem_data,
  output logic [MAX_INSTR_WIDTH-1:0] o_window,
  output logic [COUNT_WIDTH-1:0]     o_avail,
  output logic [ADDRESS_WIDTH-1:0]   o_pc,
  input  logic                       i_consume_valid,
  input  logic [LEN_WIDTH-1:0]       i_consume_len
);

  pq_state_e                state;
  logic [ADDRESS_WIDTH-1:0] fetch_addr;
  logic [1:0]               skip;
  logic                     discard;

  logic                     resp_accept;
  logic                     ring_wr;
  logic                     consume_ok;
  logic                     can_issue;
  logic [LEN_WIDTH-1:0]     advance;

  // Handshake qualification; redirect overrides consume and response.
  always_comb begin
    resp_accept = (state == PQ_WAIT) && i_mem_valid;
    ring_wr     = resp_accept && !discard && !i_pc_valid;
    consume_ok  = i_consume_valid && !i_pc_valid &&
                  (COUNT_WIDTH'(i_consume_len) <= o_avail);
    advance     = consume_ok ? i_consume_len : '0;
    can_issue   = o_avail <= COUNT_WIDTH'(QUEUE_BYTES - WORD_BYTES);
  end

  // Request FSM plus fetch address, skip/discard and PC tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= PQ_IDLE;
      o_mem_valid <= 1'b0;
      o_mem_addr  <= '0;
      fetch_addr  <= '0;
      skip        <= '0;
      discard     <= 1'b0;
      o_pc        <= '0;
    end else begin
      case (state)
        PQ_IDLE: begin
          if (!i_pc_valid && can_issue) begin
            state       <= PQ_REQ;
            o_mem_valid <= 1'b1;
            o_mem_addr  <= fetch_addr;
          end
        end
        PQ_REQ: begin
          if (i_mem_ready) begin
            state       <= PQ_WAIT;
            o_mem_valid <= 1'b0;
          end
        end
        PQ_WAIT: begin
          if (i_mem_valid) begin
            state <= PQ_IDLE;
          end
        end
        default: begin
          state       <= PQ_IDLE;
          o_mem_valid <= 1'b0;
        end
      endcase

      if (i_pc_valid) begin
        o_pc       <= i_pc;
        fetch_addr <= {i_pc[ADDRESS_WIDTH-1:2], 2'b00};
        skip       <= i_pc[1:0];
        discard    <= (state == PQ_REQ) || ((state == PQ_WAIT) && !i_mem_valid);
      end else begin
        if (consume_ok) begin
          o_pc <= o_pc + ADDRESS_WIDTH'(i_consume_len);
        end
        if (resp_accept) begin
          if (discard) begin
            discard <= 1'b0;
          end else begin
            fetch_addr <= fetch_addr + ADDRESS_WIDTH'(WORD_BYTES);
            skip       <= '0;
          end
        end
      end
    end
  end

  prefetch_byte_ring u_ring (
    .clk     (clk),
    .reset   (reset),
    .flush   (i_pc_valid),
    .wr_en   (ring_wr),
    .wr_data (i_mem_data),
    .wr_skip (skip),
    .rd_len  (advance),
    .window  (o_window),
    .count   (o_avail)
  );

endmodule
